// File: rtl/ex_stage_if.sv
// ex_stage_if: ID/EX operand bus, EX/MEM result bus and branch redirect of the execute stage.
interface ex_stage_if;
    logic        in_valid;
    logic [4:0]  in_op;
    logic [4:0]  in_rd;
    logic [31:0] PC;
    logic [31:0] rs1val;
    logic [31:0] rs2val;
    logic [31:0] LoadStoreOrjalAddress;
    logic [31:0] auipcOrlui;
    logic        flush;
    logic        mem_ready;
    logic        in_ready;
    logic        out_valid;
    logic [4:0]  out_op;
    logic [4:0]  out_rd;
    logic [31:0] out_result;
    logic [31:0] out_store_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    modport master (
        output in_valid, in_op, in_rd, PC, rs1val, rs2val, LoadStoreOrjalAddress, auipcOrlui,
        output flush, mem_ready,
        input  in_ready, out_valid, out_op, out_rd, out_result, out_store_data, redirect, redirect_pc
    );
    modport slave (
        input  in_valid, in_op, in_rd, PC, rs1val, rs2val, LoadStoreOrjalAddress, auipcOrlui,
        input  flush, mem_ready,
        output in_ready, out_valid, out_op, out_rd, out_result, out_store_data, redirect, redirect_pc
    );
endinterface

// File: rtl/ex_stage.sv
// ex_stage: RV32IM execute stage with registered EX/MEM output, branch redirect and iterative divider.
module ex_stage #(
    parameter int DIV_STEP = 1
) (
    input logic       CLK,
    input logic       RST_N,
    ex_stage_if.slave bus
);
    localparam logic [4:0] OP_ADD = 5'd0, OP_SUB = 5'd1, OP_AND = 5'd2, OP_OR = 5'd3, OP_XOR = 5'd4;
    localparam logic [4:0] OP_SLL = 5'd5, OP_SRL = 5'd6, OP_SRA = 5'd7, OP_SLT = 5'd8, OP_SLTU = 5'd9;
    localparam logic [4:0] OP_LUI = 5'd10, OP_JAL = 5'd11, OP_LOAD = 5'd12, OP_STORE = 5'd13;
    localparam logic [4:0] OP_BEQ = 5'd14, OP_BNE = 5'd15, OP_BLT = 5'd16, OP_BGE = 5'd17;
    localparam logic [4:0] OP_BLTU = 5'd18, OP_BGEU = 5'd19, OP_MUL = 5'd20;
    localparam logic [4:0] OP_DIV = 5'd21, OP_DIVU = 5'd22, OP_REM = 5'd23;
    localparam int ITERS = 32 / DIV_STEP;

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;
    state_t state_q, state_d;

    logic        out_valid_q, redirect_q;
    logic [4:0]  out_op_q, out_rd_q;
    logic [31:0] out_result_q, out_store_data_q, redirect_pc_q;

    logic [31:0] q_q, dvs_q;
    logic [32:0] r_q;
    logic [5:0]  cnt_q;
    logic        nq_q, nr_q;
    logic [4:0]  dop_q, drd_q;

    logic        in_ready, accept, done_load, take, is_div;
    logic        sgn, a_neg, b_neg, div0, ovf;
    logic [31:0] a, b, a_mag, b_mag, alu;
    logic [31:0] q_step, q_fix, r_fix, div_res;
    logic [32:0] r_step;

    assign a      = bus.rs1val;
    assign b      = bus.rs2val;
    assign is_div = bus.in_op >= OP_DIV && bus.in_op <= 5'd24;
    assign sgn    = bus.in_op == OP_DIV || bus.in_op == OP_REM;
    assign a_neg  = sgn && a[31];
    assign b_neg  = sgn && b[31];
    assign a_mag  = a_neg ? -a : a;
    assign b_mag  = b_neg ? -b : b;
    assign div0   = b == 32'd0;
    assign ovf    = sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;

    always_comb begin
        alu  = a + b;
        take = 1'b0;
        case (bus.in_op)
            OP_SUB:   alu = a - b;
            OP_AND:   alu = a & b;
            OP_OR:    alu = a | b;
            OP_XOR:   alu = a ^ b;
            OP_SLL:   alu = a << b[4:0];
            OP_SRL:   alu = a >> b[4:0];
            OP_SRA:   alu = $signed(a) >>> b[4:0];
            OP_SLT:   alu = {31'd0, $signed(a) < $signed(b)};
            OP_SLTU:  alu = {31'd0, a < b};
            OP_LUI:   alu = bus.auipcOrlui;
            OP_JAL:   begin alu = bus.PC + 32'd4; take = 1'b1; end
            OP_LOAD, OP_STORE: alu = bus.LoadStoreOrjalAddress;
            OP_BEQ:   begin alu = '0; take = a == b; end
            OP_BNE:   begin alu = '0; take = a != b; end
            OP_BLT:   begin alu = '0; take = $signed(a) < $signed(b); end
            OP_BGE:   begin alu = '0; take = $signed(a) >= $signed(b); end
            OP_BLTU:  begin alu = '0; take = a < b; end
            OP_BGEU:  begin alu = '0; take = a >= b; end
            OP_MUL:   alu = a * b;
            default:  alu = a + b;
        endcase
    end

    // Restoring division: q_q shifts the dividend out while quotient bits shift in.
    always_comb begin
        r_step = r_q;
        q_step = q_q;
        for (int k = 0; k < DIV_STEP; k++) begin
            r_step = {r_step[31:0], q_step[31]};
            q_step = {q_step[30:0], 1'b0};
            if (r_step >= {1'b0, dvs_q}) begin
                r_step    = r_step - {1'b0, dvs_q};
                q_step[0] = 1'b1;
            end
        end
    end

    assign q_fix   = nq_q ? -q_q : q_q;
    assign r_fix   = nr_q ? -r_q[31:0] : r_q[31:0];
    assign div_res = (dop_q == OP_DIV || dop_q == OP_DIVU) ? q_fix : r_fix;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.flush) state_d = S_IDLE;
        else
            case (state_q)
                S_IDLE:  state_d = (accept && is_div) ? ((div0 || ovf) ? S_DONE : S_DIV) : S_IDLE;
                S_DIV:   state_d = cnt_q == 6'd0 ? S_DONE : S_DIV;
                S_DONE:  state_d = (!out_valid_q || bus.mem_ready) ? S_IDLE : S_DONE;
                default: state_d = S_IDLE;
            endcase
    end

    always_comb begin
        in_ready  = state_q == S_IDLE && (!out_valid_q || bus.mem_ready);
        accept    = bus.in_valid && in_ready && !bus.flush;
        done_load = state_q == S_DONE && (!out_valid_q || bus.mem_ready) && !bus.flush;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            q_q   <= '0;
            r_q   <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
            nq_q  <= 1'b0;
            nr_q  <= 1'b0;
            dop_q <= '0;
            drd_q <= '0;
        end else if (accept && is_div) begin
            // Corner cases are preloaded as final results with no sign fix-up.
            q_q   <= div0 ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : a_mag;
            r_q   <= div0 ? {1'b0, a} : 33'd0;
            dvs_q <= b_mag;
            cnt_q <= 6'(ITERS - 1);
            nq_q  <= !div0 && !ovf && (a_neg ^ b_neg);
            nr_q  <= !div0 && !ovf && a_neg;
            dop_q <= bus.in_op;
            drd_q <= bus.in_rd;
        end else if (state_q == S_DIV && !bus.flush) begin
            q_q   <= q_step;
            r_q   <= r_step;
            cnt_q <= cnt_q - 6'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            out_valid_q      <= 1'b0;
            out_op_q         <= '0;
            out_rd_q         <= '0;
            out_result_q     <= '0;
            out_store_data_q <= '0;
            redirect_q       <= 1'b0;
            redirect_pc_q    <= '0;
        end else if (bus.flush) begin
            out_valid_q <= 1'b0;
            redirect_q  <= 1'b0;
        end else begin
            redirect_q <= accept && !is_div && take;
            if (accept && !is_div && take) redirect_pc_q <= bus.LoadStoreOrjalAddress;
            if (accept && !is_div) begin
                out_valid_q      <= 1'b1;
                out_op_q         <= bus.in_op;
                out_rd_q         <= bus.in_rd;
                out_result_q     <= alu;
                out_store_data_q <= b;
            end else if (done_load) begin
                out_valid_q      <= 1'b1;
                out_op_q         <= dop_q;
                out_rd_q         <= drd_q;
                out_result_q     <= div_res;
                out_store_data_q <= '0;
            end else if (bus.mem_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready       = in_ready;
    assign bus.out_valid      = out_valid_q;
    assign bus.out_op         = out_op_q;
    assign bus.out_rd         = out_rd_q;
    assign bus.out_result     = out_result_q;
    assign bus.out_store_data = out_store_data_q;
    assign bus.redirect       = redirect_q;
    assign bus.redirect_pc    = redirect_pc_q;
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed vectors with hand-computed results for the execute stage.
module tb_ex_stage;
    localparam logic [4:0] ADD = 5'd0, SRA = 5'd7, SLT = 5'd8, SLTU = 5'd9, LUI = 5'd10, JAL = 5'd11;
    localparam logic [4:0] STORE = 5'd13, BEQ = 5'd14, BNE = 5'd15, MUL = 5'd20;
    localparam logic [4:0] DIV = 5'd21, DIVU = 5'd22, REM = 5'd23, REMU = 5'd24;

    logic CLK = 1'b0;
    logic RST_N;
    int   checks = 0;
    int   errors = 0;
    int   n;
    int   seen;

    ex_stage_if bus ();
    ex_stage #(.DIV_STEP(1)) dut (.CLK(CLK), .RST_N(RST_N), .bus(bus));

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic setop(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] addr, input logic [31:0] pc);
        bus.in_valid              = 1'b1;
        bus.in_op                 = op;
        bus.in_rd                 = op + 5'd1;
        bus.rs1val                = x;
        bus.rs2val                = y;
        bus.LoadStoreOrjalAddress = addr;
        bus.PC                    = pc;
    endtask

    task automatic run_div(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y, output int cyc);
        setop(op, x, y, 32'd0, 32'd0);
        step();
        bus.in_valid = 1'b0;
        cyc = 0;
        while (!bus.in_ready && cyc < 100) begin
            cyc++;
            step();
        end
    endtask

    initial begin
        RST_N = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_op = '0;
        bus.in_rd = '0;
        bus.PC = '0;
        bus.rs1val = '0;
        bus.rs2val = '0;
        bus.LoadStoreOrjalAddress = '0;
        bus.auipcOrlui = 32'h1234_5000;
        bus.flush = 1'b0;
        bus.mem_ready = 1'b1;
        repeat (2) step();
        chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_result", bus.out_result, 32'd0);
        chk("rst_redirect", {31'd0, bus.redirect}, 32'd0);
        RST_N = 1'b1;

        setop(ADD, 32'h7FFF_FFFF, 32'd1, 32'd0, 32'd0);
        step();
        chk("add_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("add_result", bus.out_result, 32'h8000_0000);
        chk("add_rd", {27'd0, bus.out_rd}, 32'd1);
        setop(SRA, 32'h8000_0000, 32'd4, 32'd0, 32'd0);
        step();
        chk("sra_result", bus.out_result, 32'hF800_0000);
        chk("sra_op", {27'd0, bus.out_op}, 32'd7);
        setop(SLT, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0);
        step();
        chk("slt_result", bus.out_result, 32'd1);
        setop(SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0);
        step();
        chk("sltu_result", bus.out_result, 32'd0);
        setop(MUL, 32'h0001_0001, 32'h0001_0001, 32'd0, 32'd0);
        step();
        chk("mul_result", bus.out_result, 32'h0002_0001);
        setop(LUI, 32'd0, 32'd0, 32'd0, 32'd0);
        step();
        chk("lui_result", bus.out_result, 32'h1234_5000);
        setop(STORE, 32'd9, 32'hCAFE_F00D, 32'h0000_2000, 32'd0);
        step();
        chk("store_addr", bus.out_result, 32'h0000_2000);
        chk("store_data", bus.out_store_data, 32'hCAFE_F00D);
        setop(5'd27, 32'd3, 32'd4, 32'd0, 32'd0);
        step();
        chk("op27_add", bus.out_result, 32'd7);

        setop(BNE, 32'd5, 32'd6, 32'h100, 32'h80);
        step();
        chk("bne_redirect", {31'd0, bus.redirect}, 32'd1);
        chk("bne_target", bus.redirect_pc, 32'h100);
        chk("bne_result", bus.out_result, 32'd0);
        setop(BEQ, 32'd5, 32'd6, 32'h100, 32'h80);
        step();
        chk("beq_no_redirect", {31'd0, bus.redirect}, 32'd0);
        setop(JAL, 32'd0, 32'd0, 32'h200, 32'h40);
        step();
        chk("jal_link", bus.out_result, 32'h44);
        chk("jal_redirect", {31'd0, bus.redirect}, 32'd1);
        chk("jal_target", bus.redirect_pc, 32'h200);
        bus.in_valid = 1'b0;
        step();
        chk("idle_consumed", {31'd0, bus.out_valid}, 32'd0);
        chk("idle_no_redirect", {31'd0, bus.redirect}, 32'd0);

        run_div(DIV, 32'hFFFF_FFF9, 32'd2, n);
        chk("div_busy_cycles", n, 32'd33);
        chk("div_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("div_result", bus.out_result, 32'hFFFF_FFFD);
        chk("div_rd", {27'd0, bus.out_rd}, 32'd22);
        run_div(REM, 32'hFFFF_FFF9, 32'd2, n);
        chk("rem_result", bus.out_result, 32'hFFFF_FFFF);
        run_div(DIV, 32'd7, 32'hFFFF_FFFE, n);
        chk("div_pos_neg", bus.out_result, 32'hFFFF_FFFD);
        run_div(DIVU, 32'd100, 32'd7, n);
        chk("divu_result", bus.out_result, 32'd14);
        run_div(REMU, 32'd100, 32'd7, n);
        chk("remu_result", bus.out_result, 32'd2);
        run_div(DIVU, 32'd1234, 32'd0, n);
        chk("divu_zero_result", bus.out_result, 32'hFFFF_FFFF);
        chk("divu_zero_cycles", n, 32'd1);
        run_div(REM, 32'hFFFF_FFF9, 32'd0, n);
        chk("rem_zero_result", bus.out_result, 32'hFFFF_FFF9);
        run_div(REM, 32'h8000_0000, 32'hFFFF_FFFF, n);
        chk("rem_ovf_result", bus.out_result, 32'd0);
        run_div(DIV, 32'h8000_0000, 32'hFFFF_FFFF, n);
        chk("div_ovf_result", bus.out_result, 32'h8000_0000);

        bus.mem_ready = 1'b0;
        setop(ADD, 32'd1, 32'd2, 32'd0, 32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("hold_result", bus.out_result, 32'h8000_0000);
            chk("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
        end
        bus.mem_ready = 1'b1;
        #1;
        chk("release_in_ready", {31'd0, bus.in_ready}, 32'd1);
        step();
        chk("release_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("release_result", bus.out_result, 32'd3);

        setop(DIVU, 32'd1000, 32'd3, 32'd0, 32'd0);
        step();
        bus.in_valid = 1'b0;
        repeat (13) step();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        chk("flush_div_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("flush_div_in_ready", {31'd0, bus.in_ready}, 32'd1);
        setop(ADD, 32'd5, 32'd6, 32'd0, 32'd0);
        step();
        bus.in_valid = 1'b0;
        chk("post_flush_add_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("post_flush_add_result", bus.out_result, 32'd11);
        seen = 0;
        repeat (40) begin
            step();
            if (bus.out_valid) seen++;
        end
        chk("flush_no_stale", seen, 32'd0);

        setop(ADD, 32'd1, 32'd1, 32'd0, 32'd0);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_blocks_accept", {31'd0, bus.out_valid}, 32'd0);

        setop(JAL, 32'd0, 32'd0, 32'h300, 32'h80);
        step();
        bus.in_valid = 1'b0;
        bus.flush = 1'b1;
        #1;
        chk("flush_keeps_pulse", {31'd0, bus.redirect}, 32'd1);
        step();
        bus.flush = 1'b0;
        chk("flush_clears_redirect", {31'd0, bus.redirect}, 32'd0);
        chk("flush_clears_valid", {31'd0, bus.out_valid}, 32'd0);

        setop(DIVU, 32'd50, 32'd7, 32'd0, 32'd0);
        step();
        bus.in_valid = 1'b0;
        repeat (9) step();
        RST_N = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("mid_rst_result", bus.out_result, 32'd0);
        chk("mid_rst_op", {27'd0, bus.out_op}, 32'd0);
        chk("mid_rst_rd", {27'd0, bus.out_rd}, 32'd0);
        chk("mid_rst_store", bus.out_store_data, 32'd0);
        chk("mid_rst_redirect_pc", bus.redirect_pc, 32'd0);
        chk("mid_rst_redirect", {31'd0, bus.redirect}, 32'd0);
        #1;
        RST_N = 1'b1;
        step();
        chk("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        seen = 0;
        repeat (40) begin
            step();
            if (bus.out_valid) seen++;
        end
        chk("mid_rst_no_stale", seen, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
